// File: rtl/gpr_multiport.sv
// gpr_multiport
//   Parametrised general-purpose register file with NRP independent
//   combinational read ports, one write port, same-cycle write-to-read
//   bypass, an optional hardwired-zero entry 0, and a clear sequencer that
//   zeroes one entry per cycle after reset or on request.
//
// Ports
//   clk       clock, all state updates on the rising edge
//   rst_n     asynchronous active-low reset (enters CLEAR)
//   init_req  request a full clear while in RUN (wins over a same-cycle write)
//   we        write enable
//   wa        write address
//   wd        write data
//   ra        packed read addresses, port k = ra[k*AW +: AW]
//   rd        packed read data,      port k = rd[k*XLEN +: XLEN]
//   ready     registered, high while in RUN
module gpr_multiport #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int NRP      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                init_req,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic [NRP*AW-1:0]   ra,
  output logic [NRP*XLEN-1:0] rd,
  output logic                ready
);

  localparam int DEPTH = 2**AW;
  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH-1);
  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t          state, state_nxt;
  logic [AW:0]     cnt, cnt_nxt;
  logic            wr_legal;
  logic [XLEN-1:0] mem [DEPTH];

  // A write only lands in RUN, when no clear is requested, and never on the
  // hardwired-zero entry. The bypass uses the same qualification so a read
  // never forwards data that the array will not hold.
  assign wr_legal = (state == RUN) && we && !init_req &&
                    !((ZERO_REG != 0) && (wa == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
      ready <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ready <= (state_nxt == RUN);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLEAR: begin
        cnt_nxt = cnt + CNT_ONE;
        if (cnt == CNT_LAST) state_nxt = RUN;
      end
      RUN: begin
        if (init_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  // The storage array has no reset; the clear sequencer zeroes it instead.
  // While rst_n is held low the state is CLEAR with cnt at 0, so only entry 0
  // is rewritten with zero, which the following sweep repeats anyway.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[cnt[AW-1:0]] <= '0;
    else if (wr_legal)
      mem[wa] <= wd;
  end

  always_comb begin
    logic [AW-1:0] a;
    rd = '0;
    a  = '0;
    for (int k = 0; k < NRP; k++) begin
      a = ra[k*AW +: AW];
      if (state == CLEAR)
        rd[k*XLEN +: XLEN] = '0;
      else if ((ZERO_REG != 0) && (a == '0))
        rd[k*XLEN +: XLEN] = '0;
      else if (wr_legal && (wa == a))
        rd[k*XLEN +: XLEN] = wd;
      else
        rd[k*XLEN +: XLEN] = mem[a];
    end
  end

endmodule

// File: tb/tb_gpr_multiport.sv
module tb_gpr_multiport;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic              clk;
  logic              rst_n;
  logic              init_req;
  logic              we;
  logic [AW-1:0]     wa;
  logic [XLEN-1:0]   wd;
  logic [4*AW-1:0]   ra;
  logic [4*XLEN-1:0] rd1;
  logic [2*XLEN-1:0] rd0;
  logic              ready1;
  logic              ready0;

  int n_tests;
  int n_fail;

  // Reference state: register contents, whether the file is usable, and how
  // many clear edges have elapsed since the last clear began.
  logic [XLEN-1:0] m1 [DEPTH];
  logic [XLEN-1:0] m0 [DEPTH];
  bit              run_m;
  int              clr_edges;

  // Four ports, hardwired zero entry.
  gpr_multiport #(.XLEN(XLEN), .AW(AW), .NRP(4), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .we(we), .wa(wa),
    .wd(wd), .ra(ra), .rd(rd1), .ready(ready1));

  // Two ports, entry 0 ordinary; shares inputs, reads ports 0/1 of ra.
  gpr_multiport #(.XLEN(XLEN), .AW(AW), .NRP(2), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .init_req(init_req), .we(we), .wa(wa),
    .wd(wd), .ra(ra[2*AW-1:0]), .rd(rd0), .ready(ready0));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [XLEN-1:0] exp_rd(bit zr, logic [AW-1:0] a);
    if (!run_m) return '0;
    if (zr && a == 0) return '0;
    if (we && !init_req && !(zr && wa == 0) && wa == a) return wd;
    return zr ? m1[a] : m0[a];
  endfunction

  function automatic logic [AW-1:0] port_addr(int k);
    return ra[k*AW +: AW];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m1[i] = '0;
      m0[i] = '0;
    end
    run_m     = 1'b0;
    clr_edges = 0;
  endtask

  // Advance one rising edge, updating the reference with the pre-edge inputs.
  task automatic tick();
    if (rst_n) begin
      if (run_m) begin
        if (init_req) model_clear();
        else if (we) begin
          if (wa != 0) m1[wa] = wd;
          m0[wa] = wd;
        end
      end else begin
        clr_edges++;
        if (clr_edges == DEPTH) run_m = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    init_req = 1'b0;
    we       = 1'b0;
    wa       = '0;
    wd       = '0;
    ra       = '0;
  endtask

  task automatic wait_ready(int budget);
    int n;
    n = 0;
    while (!run_m && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_clear();
    we = 1'b1; wa = 5'd3; wd = 32'hDEAD_BEEF; ra = {4{5'd3}};
    #1;
    n_tests++;
    if (ready1 !== 1'b0 || ready0 !== 1'b0 || rd1 !== '0 || rd0 !== '0) begin
      n_fail++;
      $display("FAIL reset_async: ready1=%b ready0=%b rd1=%h rd0=%h required 0",
               ready1, ready0, rd1, rd0);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_tests++;
      if (ready1 !== 1'b0 || ready0 !== 1'b0 || rd1[31:0] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_clear_ready edge %0d: ready1=%b ready0=%b rd=%h required ready 0 rd 0",
                 i, ready1, ready0, rd1[31:0]);
      end
      tick();
    end
    n_tests++;
    if (ready1 !== 1'b1 || ready0 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_rise: ready1=%b ready0=%b required 1", ready1, ready0);
    end
    we = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      ra = {4{5'(a)}};
      #1;
      n_tests++;
      if (rd1[31:0] !== 32'h0 || rd0[31:0] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_entry x%0d: rd1=%h rd0=%h required 0", a, rd1[31:0], rd0[31:0]);
      end
    end
  endtask

  task automatic test_write_bypass();
    idle_inputs();
    we = 1'b1; wa = 5'd5; wd = 32'h1234_5678; ra = {15'd0, 5'd5};
    #1;
    n_tests++;
    if (rd1[31:0] !== 32'h1234_5678 || rd0[31:0] !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL bypass_x5: rd1=%h rd0=%h required 12345678", rd1[31:0], rd0[31:0]);
    end
    tick();
    we = 1'b0;
    #1;
    n_tests++;
    if (rd1[31:0] !== 32'h1234_5678 || rd0[31:0] !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL array_x5: rd1=%h rd0=%h required 12345678", rd1[31:0], rd0[31:0]);
    end
  endtask

  task automatic test_zero_reg();
    idle_inputs();
    we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF; ra = '0;
    #1;
    n_tests++;
    if (rd1[63:0] !== 64'h0 || rd0 !== {2{32'hFFFF_FFFF}}) begin
      n_fail++;
      $display("FAIL zero_write_cycle: rd1=%h rd0=%h required 0 / ffffffffffffffff",
               rd1[63:0], rd0);
    end
    tick();
    we = 1'b0;
    #1;
    n_tests++;
    if (rd1[63:0] !== 64'h0 || rd0 !== {2{32'hFFFF_FFFF}}) begin
      n_fail++;
      $display("FAIL zero_next_cycle: rd1=%h rd0=%h required 0 / ffffffffffffffff",
               rd1[63:0], rd0);
    end
  endtask

  task automatic test_multiport();
    idle_inputs();
    for (int i = 1; i <= 4; i++) begin
      we = 1'b1; wa = 5'(i); wd = 32'(i);
      tick();
    end
    we = 1'b0;
    ra = {5'd4, 5'd3, 5'd2, 5'd1};
    #1;
    n_tests++;
    if (rd1 !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
      n_fail++;
      $display("FAIL multiport_read: rd=%h required 4/3/2/1", rd1);
    end
    ra = {4{5'd2}};
    we = 1'b1; wa = 5'd2; wd = 32'd9;
    #1;
    n_tests++;
    if (rd1 !== {4{32'd9}} || rd0 !== {2{32'd9}}) begin
      n_fail++;
      $display("FAIL multiport_bypass: rd1=%h rd0=%h required all 9", rd1, rd0);
    end
    tick();
    we = 1'b0;
  endtask

  task automatic test_soft_clear();
    idle_inputs();
    we = 1'b1; wa = 5'd7; wd = 32'hAAAA_0001;
    tick();
    we = 1'b1; wa = 5'd7; wd = 32'h55; init_req = 1'b1; ra = {15'd0, 5'd7};
    #1;
    n_tests++;
    if (rd1[31:0] !== 32'hAAAA_0001) begin
      n_fail++;
      $display("FAIL clear_collision_nobypass: rd=%h required aaaa0001", rd1[31:0]);
    end
    tick();
    init_req = 1'b0; we = 1'b0;
    n_tests++;
    if (ready1 !== 1'b0 || rd1[31:0] !== 32'h0) begin
      n_fail++;
      $display("FAIL clear_ready_drop: ready=%b rd=%h required 0 0", ready1, rd1[31:0]);
    end
    for (int i = 1; i < DEPTH; i++) tick();
    n_tests++;
    if (ready1 !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_ready_early: ready=%b required 0", ready1);
    end
    tick();
    n_tests++;
    if (ready1 !== 1'b1 || rd1[31:0] !== 32'h0 || rd0[31:0] !== 32'h0) begin
      n_fail++;
      $display("FAIL clear_x7: ready=%b rd1=%h rd0=%h required 1 0 0",
               ready1, rd1[31:0], rd0[31:0]);
    end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] e;
    idle_inputs();
    for (int c = 0; c < 400; c++) begin
      init_req = ($urandom_range(0, 63) == 0);
      we       = $urandom_range(0, 1);
      wa       = 5'($urandom_range(0, 7));
      wd       = $urandom;
      for (int k = 0; k < 4; k++) ra[k*AW +: AW] = 5'($urandom_range(0, 7));
      #1;
      n_tests++;
      if (ready1 !== run_m || ready0 !== run_m) begin
        n_fail++;
        $display("FAIL rand_ready cyc %0d: ready1=%b ready0=%b required %b",
                 c, ready1, ready0, run_m);
      end
      for (int k = 0; k < 4; k++) begin
        e = exp_rd(1'b1, port_addr(k));
        n_tests++;
        if (rd1[k*XLEN +: XLEN] !== e) begin
          n_fail++;
          $display("FAIL rand_rd1 cyc %0d port %0d: got %h required %h",
                   c, k, rd1[k*XLEN +: XLEN], e);
        end
      end
      for (int k = 0; k < 2; k++) begin
        e = exp_rd(1'b0, port_addr(k));
        n_tests++;
        if (rd0[k*XLEN +: XLEN] !== e) begin
          n_fail++;
          $display("FAIL rand_rd0 cyc %0d port %0d: got %h required %h",
                   c, k, rd0[k*XLEN +: XLEN], e);
        end
      end
      tick();
    end
    idle_inputs();
    wait_ready(DEPTH + 2);
    n_tests++;
    if (ready1 !== 1'b1) begin
      n_fail++;
      $display("FAIL rand_settle: ready=%b required 1", ready1);
    end
  endtask

  task automatic test_reset_mid_clear();
    idle_inputs();
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    rst_n = 1'b0;
    model_clear();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      n_tests++;
      if (ready1 !== 1'b0 || ready0 !== 1'b0) begin
        n_fail++;
        $display("FAIL midclear_ready edge %0d: ready1=%b ready0=%b required 0",
                 i, ready1, ready0);
      end
      tick();
    end
    n_tests++;
    if (ready1 !== 1'b1 || ready0 !== 1'b1) begin
      n_fail++;
      $display("FAIL midclear_ready_rise: ready1=%b ready0=%b required 1", ready1, ready0);
    end
    ra = {4{5'd5}};
    #1;
    n_tests++;
    if (rd1[31:0] !== 32'h0 || rd0[31:0] !== 32'h0) begin
      n_fail++;
      $display("FAIL midclear_x5: rd1=%h rd0=%h required 0", rd1[31:0], rd0[31:0]);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    idle_inputs();
    model_clear();
    @(posedge clk);
    #1;
    test_reset();
    test_write_bypass();
    test_zero_reg();
    test_multiport();
    test_soft_clear();
    test_random();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
